// File: rtl/debounce_switch_multi.sv
// N-channel switch debouncer: 2-flop synchroniser, per-channel stability counter, clean level plus rise/fall strobes.
// Optional long-press strobe on o_Hold is built when DEBOUNCE_LONG_PRESS_EN is defined; otherwise o_Hold is tied low.
module debounce_switch_multi #(
   parameter int C_NUM_CH     = 4,
   parameter int C_TIME_LIMIT = 250000,
   parameter int C_INIT       = 0,
   parameter int C_HOLD_LIMIT = 5000000
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic [C_NUM_CH-1:0] i_Switch,
   output logic [C_NUM_CH-1:0] o_Switch,
   output logic [C_NUM_CH-1:0] o_Rise,
   output logic [C_NUM_CH-1:0] o_Fall,
   output logic [C_NUM_CH-1:0] o_Hold
);

   localparam int                  CNT_W    = $clog2(C_TIME_LIMIT + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(C_TIME_LIMIT - 1);
   localparam logic                INIT_LVL = (C_INIT != 0);
   localparam logic [C_NUM_CH-1:0] INIT_VEC = {C_NUM_CH{INIT_LVL}};

   if (C_NUM_CH < 1 || C_TIME_LIMIT < 1 || C_HOLD_LIMIT < 1 || (C_INIT != 0 && C_INIT != 1)) begin : g_bad_param
      $error("debounce_switch_multi: illegal parameter value");
   end

   logic [C_NUM_CH-1:0] sync_p0;
   logic [C_NUM_CH-1:0] sync_p1;
   logic [CNT_W-1:0]    cnt_q [C_NUM_CH];
   logic [CNT_W-1:0]    cnt_d [C_NUM_CH];
   logic [C_NUM_CH-1:0] state_d;
   logic [C_NUM_CH-1:0] rise_d;
   logic [C_NUM_CH-1:0] fall_d;

   // Stage p0/p1: two-flop synchroniser on the raw pins
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         sync_p0 <= INIT_VEC;
         sync_p1 <= INIT_VEC;
      end else begin
         sync_p0 <= i_Switch;
         sync_p1 <= sync_p0;
      end
   end

   // A level is accepted only after C_TIME_LIMIT consecutive differing cycles; any agreeing cycle restarts the count
   always_comb begin
      state_d = o_Switch;
      rise_d  = '0;
      fall_d  = '0;
      for (int n = 0; n < C_NUM_CH; n++) begin
         cnt_d[n] = '0;
         if (sync_p1[n] != o_Switch[n]) begin
            if (cnt_q[n] == CNT_LAST) begin
               state_d[n] = sync_p1[n];
               rise_d[n]  = sync_p1[n];
               fall_d[n]  = ~sync_p1[n];
            end else begin
               cnt_d[n] = cnt_q[n] + 1'b1;
            end
         end
      end
   end

   // Stage p2: stable state, counters and edge strobes
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_Switch <= INIT_VEC;
         o_Rise   <= '0;
         o_Fall   <= '0;
         for (int n = 0; n < C_NUM_CH; n++) cnt_q[n] <= '0;
      end else begin
         o_Switch <= state_d;
         o_Rise   <= rise_d;
         o_Fall   <= fall_d;
         for (int n = 0; n < C_NUM_CH; n++) cnt_q[n] <= cnt_d[n];
      end
   end

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam int                HOLD_W    = $clog2(C_HOLD_LIMIT + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(C_HOLD_LIMIT);
   localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(C_HOLD_LIMIT - 1);

   function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] h);
      return (h == HOLD_MAX) ? h : h + 1'b1;
   endfunction

   logic [HOLD_W-1:0]   hold_q [C_NUM_CH];
   logic [HOLD_W-1:0]   hold_d [C_NUM_CH];
   logic [C_NUM_CH-1:0] hold_fire;

   // The accepting-rise cycle is hold count 0; saturation at HOLD_MAX gives one strobe per press
   always_comb begin
      hold_fire = '0;
      for (int n = 0; n < C_NUM_CH; n++) begin
         hold_d[n] = '0;
         if (state_d[n]) begin
            hold_d[n]    = rise_d[n] ? '0 : hold_sat_inc(hold_q[n]);
            hold_fire[n] = (hold_d[n] == HOLD_FIRE);
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_Hold <= '0;
         for (int n = 0; n < C_NUM_CH; n++) hold_q[n] <= '0;
      end else begin
         o_Hold <= hold_fire;
         for (int n = 0; n < C_NUM_CH; n++) hold_q[n] <= hold_d[n];
      end
   end
`else
   assign o_Hold = '0;
`endif

   a_rise_fall_excl : assert property (@(posedge i_Clk) !(|(o_Rise & o_Fall)));
   a_rise_level     : assert property (@(posedge i_Clk) !(|(o_Rise & ~o_Switch)));
   a_fall_level     : assert property (@(posedge i_Clk) !(|(o_Fall & o_Switch)));

endmodule

// File: tb/tb_debounce_switch_multi.sv
// Scoreboard bench for debounce_switch_multi (4 channels, time limit 4, hold limit 10).
module tb_debounce_switch_multi;

   localparam int NCH  = 4;
   localparam int LIM  = 4;
   localparam int HOLD = 10;
   localparam int LAT  = 2 + LIM;

   logic           clk = 1'b0;
   logic           i_Rst;
   logic [NCH-1:0] i_Switch;
   logic [NCH-1:0] o_Switch, o_Rise, o_Fall, o_Hold;

   debounce_switch_multi #(
      .C_NUM_CH(NCH), .C_TIME_LIMIT(LIM), .C_INIT(0), .C_HOLD_LIMIT(HOLD)
   ) dut (
      .i_Clk(clk), .i_Rst(i_Rst), .i_Switch(i_Switch),
      .o_Switch(o_Switch), .o_Rise(o_Rise), .o_Fall(o_Fall), .o_Hold(o_Hold)
   );

   always #5 clk = ~clk;

   typedef struct {
      int             cyc;
      logic [NCH-1:0] rise;
      logic [NCH-1:0] fall;
      logic [NCH-1:0] hold;
      logic [NCH-1:0] sw;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;
   int   c;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, act, req);
      end
   endtask

   task automatic push(input int t, input logic [NCH-1:0] r, input logic [NCH-1:0] f,
                       input logic [NCH-1:0] h, input logic [NCH-1:0] s);
      exp_t e;
      e.cyc = t; e.rise = r; e.fall = f; e.hold = h; e.sw = s;
      q.push_back(e);
   endtask

   // Rise plus the matching long-press strobe when that feature is built
   task automatic push_press(input int t, input logic [NCH-1:0] m, input logic [NCH-1:0] s);
      push(t, m, '0, '0, s);
`ifdef DEBOUNCE_LONG_PRESS_EN
      push(t + HOLD - 1, '0, '0, m, s);
`endif
   endtask

   // Monitor: every strobe cycle must match the head of the queue; overdue entries are misses
   always @(negedge clk) begin
      if (mon_en) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missed_strobe: expected at cyc %0d, no strobe arrived (now %0d)", q[0].cyc, cyc);
            void'(q.pop_front());
         end
         if (|{o_Rise, o_Fall, o_Hold}) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
               mon_e = q.pop_front();
               chk("rise", o_Rise, mon_e.rise);
               chk("fall", o_Fall, mon_e.fall);
               chk("hold", o_Hold, mon_e.hold);
               chk("level", o_Switch, mon_e.sw);
            end else begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_strobe @cyc %0d: rise %b fall %b hold %b, expected none",
                        cyc, o_Rise, o_Fall, o_Hold);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with all pins high
      i_Rst = 1'b1;
      i_Switch = 4'hF;
      @(negedge clk);
      mon_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_level", o_Switch, 4'h0);
         chk("rst_rise", o_Rise, 4'h0);
         chk("rst_fall", o_Fall, 4'h0);
         chk("rst_hold", o_Hold, 4'h0);
         @(negedge clk);
      end
      i_Rst = 1'b0;
      i_Switch = 4'h0;
      repeat (4) @(negedge clk);
      chk("idle_level", o_Switch, 4'h0);

      // Clean press on ch0, held long enough for a single long-press strobe
      c = cyc; i_Switch = 4'b0001;
      push_press(c + LAT, 4'b0001, 4'b0001);
      repeat (30) @(negedge clk);
      c = cyc; i_Switch = 4'b0000;
      push(c + LAT, '0, 4'b0001, '0, 4'b0000);
      repeat (10) @(negedge clk);

      // Bounce on ch1: 1,0,1,0 single cycles then settle high
      for (int i = 0; i < 4; i++) begin
         i_Switch = (i % 2 == 0) ? 4'b0010 : 4'b0000;
         @(negedge clk);
      end
      c = cyc; i_Switch = 4'b0010;
      push_press(c + LAT, 4'b0010, 4'b0010);
      repeat (20) @(negedge clk);
      c = cyc; i_Switch = 4'b0000;
      push(c + LAT, '0, 4'b0010, '0, 4'b0000);
      repeat (10) @(negedge clk);

      // ch2 and ch3 together, then ch2 released alone, then ch3
      c = cyc; i_Switch = 4'b1100;
      push_press(c + LAT, 4'b1100, 4'b1100);
      repeat (20) @(negedge clk);
      c = cyc; i_Switch = 4'b1000;
      push(c + LAT, '0, 4'b0100, '0, 4'b1000);
      repeat (10) @(negedge clk);
      chk("ch3_still_high", o_Switch, 4'b1000);
      c = cyc; i_Switch = 4'b0000;
      push(c + LAT, '0, 4'b1000, '0, 4'b0000);
      repeat (10) @(negedge clk);

      // Reset one cycle before ch0 would be accepted; latency restarts from deassertion
      i_Switch = 4'b0001;
      repeat (LAT - 1) @(negedge clk);
      i_Rst = 1'b1;
      @(negedge clk);
      chk("midrst_level", o_Switch, 4'b0000);
      i_Rst = 1'b0;
      c = cyc;
      push_press(c + LAT, 4'b0001, 4'b0001);
      repeat (LAT - 1) @(negedge clk);
      chk("midrst_not_yet", o_Switch, 4'b0000);
      repeat (20) @(negedge clk);
      c = cyc; i_Switch = 4'b0000;
      push(c + LAT, '0, 4'b0001, '0, 4'b0000);
      repeat (12) @(negedge clk);

      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: %0d expected strobes outstanding, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
